// File: rtl/age_issue_picker.sv
// age_issue_picker: age-matrix oldest-ready picker for an issue queue.
// age_q[i][j] = 1 means entry i is older than entry j. Each cycle the
// DEQ_WIDTH oldest ready entries are presented combinationally as picks.
// Removal (dequeue or flush) happens before enqueue, so an entry that is
// re-allocated in the same cycle comes back as the youngest entry.
// Optional feature: define AGE_ISSUE_PICKER_OLDEST_EN to add oldest_oh, the
// oldest valid entry regardless of ready.
module age_issue_picker #(
   parameter int DEPTH     = 8,
   parameter int ENQ_WIDTH = 2,
   parameter int DEQ_WIDTH = 2,
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [ENQ_WIDTH*DEPTH-1:0]   enq_oh,
   input  logic [DEPTH-1:0]             entry_ready,
   input  logic [DEQ_WIDTH-1:0]         deq_fire,
   input  logic [DEPTH-1:0]             flush_mask,
   output logic [DEQ_WIDTH-1:0]         pick_valid,
   output logic [DEQ_WIDTH*DEPTH-1:0]   pick_oh,
   output logic [DEPTH-1:0]             entry_valid,
   output logic [CNT_W-1:0]             valid_cnt,
   output logic                         err_sticky
`ifdef AGE_ISSUE_PICKER_OLDEST_EN
   ,
   output logic [DEPTH-1:0]             oldest_oh
`endif
);

   localparam logic [DEPTH-1:0] ONE_D = {{(DEPTH-1){1'b0}}, 1'b1};

   logic [DEPTH-1:0]            valid_q, valid_d;
   logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        err_q, err_d;

   logic [DEPTH-1:0]            cand_s;
   logic [DEPTH-1:0]            leave_s;
   logic [DEPTH-1:0]            survive_s;
   logic [DEPTH-1:0]            enq_any_s;
   logic [CNT_W-1:0]            rank_s [DEPTH];

   assign cand_s      = valid_q & entry_ready;
   assign survive_s   = valid_q & ~leave_s;
   assign entry_valid = valid_q;
   assign valid_cnt   = cnt_q;
   assign err_sticky  = err_q;

   // Rank of each candidate: how many other candidates are older than it.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         rank_s[i] = '0;
         for (int j = 0; j < DEPTH; j++) begin
            rank_s[i] = rank_s[i] + {{(CNT_W-1){1'b0}}, (cand_s[j] & age_q[j][i] & (i != j))};
         end
      end
   end

   // Pick k is the candidate whose rank equals k; ranks are unique among candidates.
   always_comb begin
      pick_oh    = '0;
      pick_valid = '0;
      for (int k = 0; k < DEQ_WIDTH; k++) begin
         for (int i = 0; i < DEPTH; i++) begin
            pick_oh[k*DEPTH + i] = cand_s[i] & (int'(rank_s[i]) == k);
         end
         pick_valid[k] = |pick_oh[k*DEPTH +: DEPTH];
      end
   end

   // Entries leaving this cycle: flushed ones plus fired picks that exist.
   always_comb begin
      leave_s = flush_mask;
      for (int k = 0; k < DEQ_WIDTH; k++) begin
         leave_s = leave_s | (pick_oh[k*DEPTH +: DEPTH] & {DEPTH{deq_fire[k] & pick_valid[k]}});
      end
   end

   // Next age matrix: clear leaving rows/columns, then enqueue ports in program order.
   always_comb begin
      logic [DEPTH-1:0] seen;
      age_d     = age_q;
      seen      = '0;
      enq_any_s = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            age_d[i][j] = age_d[i][j] & ~leave_s[i] & ~leave_s[j];
         end
      end
      for (int p = 0; p < ENQ_WIDTH; p++) begin
         for (int e = 0; e < DEPTH; e++) begin
            if (enq_oh[p*DEPTH + e]) begin
               enq_any_s[e] = 1'b1;
               for (int j = 0; j < DEPTH; j++) begin
                  if (j == e) begin
                     age_d[e][e] = 1'b0;
                  end else begin
                     // survivors and earlier-port enqueues are older than e
                     age_d[j][e] = survive_s[j] | seen[j];
                     age_d[e][j] = 1'b0;
                  end
               end
            end else begin
               enq_any_s[e] = enq_any_s[e];
            end
         end
         seen = seen | enq_oh[p*DEPTH +: DEPTH];
      end
   end

   // Illegal enqueue detection: multi-hot slice, busy target, or port collision.
   always_comb begin
      logic [DEPTH-1:0] seen;
      logic [DEPTH-1:0] slice;
      err_d = err_q;
      seen  = '0;
      for (int p = 0; p < ENQ_WIDTH; p++) begin
         slice = enq_oh[p*DEPTH +: DEPTH];
         err_d = err_d | (|(slice & (slice - ONE_D))) | (|(slice & survive_s)) | (|(slice & seen));
         seen  = seen | slice;
      end
   end

   // Next occupancy vector and its population count.
   always_comb begin
      valid_d = survive_s | enq_any_s;
      cnt_d   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt_d = cnt_d + {{(CNT_W-1){1'b0}}, valid_d[i]};
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         age_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         age_q   <= age_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

`ifdef AGE_ISSUE_PICKER_OLDEST_EN
   // Oldest valid entry regardless of ready: valid with no valid entry older.
   always_comb begin
      logic older;
      oldest_oh = '0;
      for (int i = 0; i < DEPTH; i++) begin
         older = 1'b0;
         for (int j = 0; j < DEPTH; j++) begin
            older = older | (valid_q[j] & age_q[j][i] & (i != j));
         end
         oldest_oh[i] = valid_q[i] & ~older;
      end
   end
`endif

endmodule

// File: tb/tb_age_issue_picker.sv
// Scoreboard bench for age_issue_picker. The reference model keeps the valid
// entries as an ordered list (oldest first); picks are the first ready
// entries in that list. Stimulus pushes expected outputs into a queue and a
// negedge monitor pops and compares them.
module tb_age_issue_picker;

   localparam int DEPTH = 8;
   localparam int ENQ   = 2;
   localparam int DEQ   = 2;
   localparam int CW    = 4;

   logic                   clock = 1'b0;
   logic                   reset_n = 1'b0;
   logic [ENQ*DEPTH-1:0]   enq_oh = '0;
   logic [DEPTH-1:0]       entry_ready = '0;
   logic [DEQ-1:0]         deq_fire = '0;
   logic [DEPTH-1:0]       flush_mask = '0;
   logic [DEQ-1:0]         pick_valid;
   logic [DEQ*DEPTH-1:0]   pick_oh;
   logic [DEPTH-1:0]       entry_valid;
   logic [CW-1:0]          valid_cnt;
   logic                   err_sticky;
`ifdef AGE_ISSUE_PICKER_OLDEST_EN
   logic [DEPTH-1:0]       oldest_oh;
`endif

   typedef struct {
      logic [DEQ-1:0]       pv;
      logic [DEQ*DEPTH-1:0] poh;
      logic [DEPTH-1:0]     ev;
      logic [CW-1:0]        cnt;
      logic                 err;
      logic [DEPTH-1:0]     old;
      bit                   skip;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_x;
   int   checks = 0;
   int   errors = 0;
   int   ord[$];
   int   m_picks[$];
   bit   m_err = 1'b0;
   bit   m_skip = 1'b0;

   always #5 clock = ~clock;

   age_issue_picker #(.DEPTH(DEPTH), .ENQ_WIDTH(ENQ), .DEQ_WIDTH(DEQ)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .enq_oh      (enq_oh),
      .entry_ready (entry_ready),
      .deq_fire    (deq_fire),
      .flush_mask  (flush_mask),
      .pick_valid  (pick_valid),
      .pick_oh     (pick_oh),
      .entry_valid (entry_valid),
      .valid_cnt   (valid_cnt),
      .err_sticky  (err_sticky)
`ifdef AGE_ISSUE_PICKER_OLDEST_EN
      ,
      .oldest_oh   (oldest_oh)
`endif
   );

   function automatic void cmp(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endfunction

   // Reference: first DEQ ready entries in age order.
   function automatic void calc_picks(input logic [DEPTH-1:0] rdy);
      m_picks = {};
      foreach (ord[i]) begin
         if (rdy[ord[i]] && m_picks.size() < DEQ) m_picks.push_back(ord[i]);
      end
   endfunction

   task automatic step(input int e0, input int e1, input logic [DEPTH-1:0] rdy,
                       input logic [DEQ-1:0] deq, input logic [DEPTH-1:0] fl);
      exp_t x;
      int en[ENQ];
      int nxt[$];
      logic [DEPTH-1:0] leave;
      bit clash;
      en[0] = e0;
      en[1] = e1;
      @(posedge clock);
      #1;
      enq_oh = '0;
      for (int p = 0; p < ENQ; p++) if (en[p] >= 0) enq_oh[p*DEPTH + en[p]] = 1'b1;
      entry_ready = rdy;
      deq_fire    = deq;
      flush_mask  = fl;
      calc_picks(rdy);
      x.pv = '0; x.poh = '0; x.ev = '0; x.old = '0;
      foreach (m_picks[k]) begin
         x.pv[k] = 1'b1;
         x.poh[k*DEPTH + m_picks[k]] = 1'b1;
      end
      foreach (ord[i]) x.ev[ord[i]] = 1'b1;
      if (ord.size() > 0) x.old[ord[0]] = 1'b1;
      x.cnt  = CW'(ord.size());
      x.err  = m_err;
      x.skip = m_skip;
      exp_q.push_back(x);
      // model update: removal first, then enqueue in port order
      leave = fl;
      foreach (m_picks[k]) if (deq[k]) leave[m_picks[k]] = 1'b1;
      nxt = {};
      foreach (ord[i]) if (!leave[ord[i]]) nxt.push_back(ord[i]);
      for (int p = 0; p < ENQ; p++) begin
         if (en[p] >= 0) begin
            clash = 1'b0;
            foreach (nxt[i]) if (nxt[i] == en[p]) clash = 1'b1;
            if (clash) begin
               m_err  = 1'b1;
               m_skip = 1'b1;
            end else begin
               nxt.push_back(en[p]);
            end
         end
      end
      ord = nxt;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      #1;
      reset_n     = 1'b0;
      enq_oh      = '0;
      deq_fire    = '0;
      flush_mask  = '0;
      entry_ready = '1;
      #1;
      cmp("rst_pick_valid", pick_valid, 0);
      cmp("rst_pick_oh", pick_oh, 0);
      cmp("rst_entry_valid", entry_valid, 0);
      cmp("rst_valid_cnt", valid_cnt, 0);
      cmp("rst_err_sticky", err_sticky, 0);
`ifdef AGE_ISSUE_PICKER_OLDEST_EN
      cmp("rst_oldest_oh", oldest_oh, 0);
`endif
      ord    = {};
      m_err  = 1'b0;
      m_skip = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // Monitor: outputs are presented every cycle; compare against the scoreboard.
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         mon_x = exp_q.pop_front();
         cmp("sb_err_sticky", err_sticky, mon_x.err);
         if (!mon_x.skip) begin
            cmp("sb_pick_valid", pick_valid, mon_x.pv);
            cmp("sb_pick_oh", pick_oh, mon_x.poh);
            cmp("sb_entry_valid", entry_valid, mon_x.ev);
            cmp("sb_valid_cnt", valid_cnt, mon_x.cnt);
`ifdef AGE_ISSUE_PICKER_OLDEST_EN
            cmp("sb_oldest_oh", oldest_oh, mon_x.old);
`endif
         end
      end
   end

   initial begin
      logic [DEPTH-1:0] rdy, fl, leave;
      logic [DEQ-1:0]   deq;
      int free[$];
      int e0, e1, idx;

      do_reset();

      // enqueue 5,2,7 over three cycles, then all ready
      step(5, -1, 8'h00, 2'b00, 8'h00);
      step(2, -1, 8'h00, 2'b00, 8'h00);
      step(7, -1, 8'h00, 2'b00, 8'h00);
      step(-1, -1, 8'hFF, 2'b00, 8'h00);
      cmp("seq_pick0", pick_oh[7:0], 8'h20);
      cmp("seq_pick1", pick_oh[15:8], 8'h04);

      // same-cycle enqueue: port 0 is older
      step(-1, -1, 8'h00, 2'b00, 8'hFF);
      step(3, 1, 8'h00, 2'b00, 8'h00);
      step(-1, -1, 8'hFF, 2'b00, 8'h00);
      cmp("port_pick0", pick_oh[7:0], 8'h08);
      cmp("port_pick1", pick_oh[15:8], 8'h02);

      // full queue, only 4 and 6 ready, fire both picks
      step(-1, -1, 8'h00, 2'b00, 8'hFF);
      step(4, 6, 8'h00, 2'b00, 8'h00);
      step(0, 1, 8'h00, 2'b00, 8'h00);
      step(2, 3, 8'h00, 2'b00, 8'h00);
      step(5, 7, 8'h00, 2'b00, 8'h00);
      step(-1, -1, 8'h50, 2'b11, 8'h00);
      cmp("full_cnt", valid_cnt, 8);
      cmp("full_pick0", pick_oh[7:0], 8'h10);
      cmp("full_pick1", pick_oh[15:8], 8'h40);
      step(-1, -1, 8'h00, 2'b00, 8'h00);
      cmp("deq2_cnt", valid_cnt, 6);
      cmp("deq2_valid", entry_valid, 8'hAF);

      // entry 2 dequeued and re-enqueued in the same cycle becomes youngest
      step(2, -1, 8'h04, 2'b01, 8'h00);
      cmp("reenq_pick0", pick_oh[7:0], 8'h04);
      step(-1, -1, 8'h24, 2'b00, 8'h00);
      cmp("reenq_pick0_after", pick_oh[7:0], 8'h20);
      cmp("reenq_pick1_after", pick_oh[15:8], 8'h04);

      // fill, flush upper half, then illegal enqueue to a valid entry
      step(4, 6, 8'h00, 2'b00, 8'h00);
      step(-1, -1, 8'h00, 2'b00, 8'hF0);
      cmp("preflush_cnt", valid_cnt, 8);
      step(-1, -1, 8'h00, 2'b00, 8'h00);
      cmp("flush_valid", entry_valid, 8'h0F);
      cmp("flush_cnt", valid_cnt, 4);
      step(1, -1, 8'h00, 2'b00, 8'h00);
      cmp("pre_err", err_sticky, 0);
      step(-1, -1, 8'h00, 2'b00, 8'h00);
      cmp("err_set", err_sticky, 1);

      // reset mid-operation with six entries valid
      do_reset();
      step(0, 1, 8'h00, 2'b00, 8'h00);
      step(2, 3, 8'h00, 2'b00, 8'h00);
      step(4, 5, 8'h00, 2'b00, 8'h00);
      step(-1, -1, 8'hFF, 2'b00, 8'h00);
      cmp("six_cnt", valid_cnt, 6);
      cmp("six_pick_valid", pick_valid, 2'b11);
      do_reset();
      step(6, -1, 8'h00, 2'b00, 8'h00);
      step(2, -1, 8'h00, 2'b00, 8'h00);
      step(-1, -1, 8'hFF, 2'b00, 8'h00);
      cmp("postrst_pick0", pick_oh[7:0], 8'h40);
`ifdef AGE_ISSUE_PICKER_OLDEST_EN
      cmp("postrst_oldest", oldest_oh, 8'h40);
`endif

      // randomized legal traffic
      for (int n = 0; n < 1500; n++) begin
         rdy = DEPTH'($urandom);
         deq = DEQ'($urandom);
         fl  = ($urandom_range(0, 7) == 0) ? DEPTH'($urandom & $urandom) : 8'h00;
         calc_picks(rdy);
         leave = fl;
         foreach (m_picks[k]) if (deq[k]) leave[m_picks[k]] = 1'b1;
         free = {};
         for (int e = 0; e < DEPTH; e++) begin
            bit busy;
            busy = 1'b0;
            foreach (ord[i]) if (ord[i] == e && !leave[e]) busy = 1'b1;
            if (!busy) free.push_back(e);
         end
         e0 = -1;
         e1 = -1;
         if (free.size() > 0 && $urandom_range(0, 3) != 0) begin
            idx = $urandom_range(0, free.size() - 1);
            e0 = free[idx];
            free.delete(idx);
         end
         if (free.size() > 0 && $urandom_range(0, 3) != 0) begin
            idx = $urandom_range(0, free.size() - 1);
            e1 = free[idx];
            free.delete(idx);
         end
         step(e0, e1, rdy, deq, fl);
      end

      repeat (2) @(posedge clock);
      cmp("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/age_issue_picker.md
AGE_ISSUE_PICKER -- requirements
Module: age_issue_picker

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of issue-queue entries tracked (2..32).
REQ-002 SHALL have parameter ENQ_WIDTH, default 2, meaning the number of enqueue ports per cycle; port 0 is program-older.
REQ-003 SHALL have parameter DEQ_WIDTH, default 2, meaning the number of oldest-ready picks per cycle.
REQ-004 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port enq_oh  input  ENQ_WIDTH*DEPTH  one-hot (or zero) target entry per enqueue port; slice p is port p.
REQ-007 SHALL have port entry_ready  input  DEPTH  operands-ready per entry.
REQ-008 SHALL have port deq_fire  input  DEQ_WIDTH  pick k issued this cycle.
REQ-009 SHALL have port flush_mask  input  DEPTH  entries to kill this cycle.
REQ-010 SHALL have port pick_valid  output  DEQ_WIDTH  pick k exists.
REQ-011 SHALL have port pick_oh  output  DEQ_WIDTH*DEPTH  one-hot entry of pick k.
REQ-012 SHALL have port entry_valid  output  DEPTH  internal occupancy vector.
REQ-013 SHALL have port valid_cnt  output  $clog2(DEPTH+1)  popcount of entry_valid.
REQ-014 SHALL have port err_sticky  output  1  illegal-enqueue flag, held until reset.

Function
REQ-015 SHALL hold age matrix age[i][j] (i != j), 1 = entry i older than entry j; diagonal unused.
REQ-016 SHALL define candidate set C = entry_valid & entry_ready from registered state; picks are combinational, zero-cycle latency.
REQ-017 SHALL compute rank(i) = count of j in C with age[j][i]=1; pick k selects the unique i in C with rank(i)=k, pick_valid[k]=0 if |C| <= k.
REQ-018 SHALL ignore deq_fire[k] when pick_valid[k]=0; deq_fire[k] with pick_valid[k]=1 clears entry_valid and row/column of that entry next edge.
REQ-019 SHALL clear entry_valid and row/column for every flush_mask bit next edge; flush of an invalid entry is a no-op.
REQ-020 SHALL on enqueue of entry e via port p set entry_valid[e], age[j][e]=1 for every j surviving the cycle (valid, not dequeued, not flushed) and every entry enqueued by port q<p, and age[e][j]=0 otherwise.
REQ-021 SHALL, when enqueue targets an entry also dequeued or flushed the same cycle, apply removal first then enqueue; entry ends valid and youngest.
REQ-022 SHALL set err_sticky when enqueue targets an entry valid and not leaving, two ports target the same entry, or an enq_oh slice has >1 bit set; state update for that entry is then undefined but other entries are unaffected.
REQ-023 SHALL update valid_cnt the same edge as entry_valid; full (valid_cnt=DEPTH) and empty (0) need no extra signalling.

Reset
REQ-024 SHALL on reset_n low asynchronously clear age matrix, entry_valid, valid_cnt, err_sticky; pick_valid and pick_oh read 0 throughout reset.
REQ-025 SHALL treat reset mid-operation as discarding all entries; first enqueue after release is the oldest entry.

Configuration
REQ-026 SHALL, with macro AGE_ISSUE_PICKER_OLDEST_EN defined, add output oldest_oh [DEPTH] = one-hot of the valid entry with no valid older entry regardless of ready, 0 when empty.
REQ-027 SHALL, without AGE_ISSUE_PICKER_OLDEST_EN, omit port oldest_oh and its logic; all other behaviour identical.

Verification
REQ-028 SHALL cover: DEPTH=8, enqueue entries 5,2,7 over three cycles, all ready -> pick_oh[0]=entry 5, pick_oh[1]=entry 2.
REQ-029 SHALL cover: same cycle port0->3, port1->1, both ready -> pick 0=entry 3, pick 1=entry 1.
REQ-030 SHALL cover: entries 0..7 full, only 6 and 4 ready (4 enqueued first) -> pick0=4, pick1=6; deq_fire=2'b11 -> valid_cnt=6 next cycle.
REQ-031 SHALL cover: entry 2 dequeued and re-enqueued same cycle with entry 5 valid -> entry 2 younger than 5, pick0=5 when both ready.
REQ-032 SHALL cover: flush_mask=8'hF0 on full queue -> entry_valid=8'h0F, valid_cnt=4; enqueue to valid entry 1 -> err_sticky=1.
REQ-033 SHALL cover: reset_n asserted with 6 entries valid -> all outputs 0 immediately; with OLDEST_EN, oldest_oh tracks first post-reset enqueue.
